// File: rtl/rvfi_pkg.sv
// rtl/rvfi_pkg.sv - RVFI monitor payload, entry and sequencer state types
package rvfi_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [31:0]     insn;
    logic            halt;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_rmask;
    logic [3:0]      mem_wmask;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
  } rvfi_pkt_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [63:0] order;
    rvfi_pkt_t   pkt;
  } rvfi_entry_t;

endpackage

// File: rtl/rvfi_fifo_2w1r.sv
// rtl/rvfi_fifo_2w1r.sv - circular buffer with up to two writes and one read per cycle
module rvfi_fifo_2w1r
  import rvfi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en0,
  input  logic                   wr_en1,
  input  rvfi_entry_t            wr_data0,
  input  rvfi_entry_t            wr_data1,
  input  logic                   rd_en,
  output rvfi_entry_t            rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  rvfi_entry_t   mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW-1:0] widx0;
  logic [AW-1:0] widx1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign widx0   = wptr[AW-1:0];
  assign widx1   = wptr[AW-1:0] + AW'(1);
  assign count   = wptr - rptr;
  assign rd_data = mem[rptr[AW-1:0]];

  // Storage writes; lane1 always lands directly behind lane0.
  always_ff @(posedge clk) begin
    if (wr_en0) mem[widx0] <= wr_data0;
    if (wr_en1) mem[widx1] <= wr_data1;
  end

  // Pointer advance by number written and read.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + PW'(wr_en0) + PW'(wr_en1);
      if (rd_en) rptr <= rptr + PW'(1);
    end
  end

endmodule

// File: rtl/rvfi_retire_sequencer.sv
// rtl/rvfi_retire_sequencer.sv - serialises dual-lane retirements onto one RVFI monitor port
module rvfi_retire_sequencer
  import rvfi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ret_valid,
  input  rvfi_pkt_t   ret_pkt0,
  input  rvfi_pkt_t   ret_pkt1,
  output logic        ret_ready,
  output logic        mon_valid,
  output logic [63:0] mon_order,
  output rvfi_pkt_t   mon_pkt,
  output logic        mon_error,
  output logic        halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  seq_state_t  state;
  logic [63:0] order_cnt;
  logic [CW-1:0] count;
  rvfi_entry_t head;
  rvfi_entry_t wr0;
  rvfi_entry_t wr1;
  logic        push0;
  logic        push1;
  logic        pop;
  logic        halt_accept;
  logic        bad_input;
  logic        pc_break;
  logic [31:0] last_pc;
  logic        have_last;

  // Two free slots are required so a dual push can never overflow.
  assign ret_ready = (state == RUN) && (count <= CW'(DEPTH - 2));

  // Push/pop decode; a halting lane0 swallows lane1 silently.
  always_comb begin
    push0       = ret_ready && ret_valid[0];
    push1       = push0 && ret_valid[1] && !ret_pkt0.halt;
    halt_accept = (push0 && ret_pkt0.halt) || (push1 && ret_pkt1.halt);
    bad_input   = (ret_valid == 2'b10) || ((|ret_valid) && !ret_ready);
    pop         = (count != '0);
    pc_break    = mon_valid && have_last && (mon_pkt.pc_rdata != last_pc);
    wr0         = '{order: order_cnt, pkt: ret_pkt0};
    wr1         = '{order: order_cnt + 64'd1, pkt: ret_pkt1};
  end

  rvfi_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en0   (push0),
    .wr_en1   (push1),
    .wr_data0 (wr0),
    .wr_data1 (wr1),
    .rd_en    (pop),
    .rd_data  (head),
    .count    (count)
  );

  // FSM, order stamping, output registers, PC continuity and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      order_cnt <= '0;
      mon_valid <= 1'b0;
      mon_order <= '0;
      mon_pkt   <= '0;
      mon_error <= 1'b0;
      halted    <= 1'b0;
      last_pc   <= '0;
      have_last <= 1'b0;
    end else begin
      order_cnt <= order_cnt + 64'(push0) + 64'(push1);
      mon_valid <= pop;
      if (pop) begin
        mon_order <= head.order;
        mon_pkt   <= head.pkt;
      end
      if (mon_valid) begin
        last_pc   <= mon_pkt.pc_wdata;
        have_last <= 1'b1;
      end
      if (bad_input || pc_break) mon_error <= 1'b1;
      case (state)
        RUN:    if (halt_accept) state <= DRAIN;
        DRAIN: begin
          if (count == '0 && mon_valid && mon_pkt.halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_retire_sequencer.sv
// tb/tb_rvfi_retire_sequencer.sv - randomized bench with queue-based reference model
module tb_rvfi_retire_sequencer;
  import rvfi_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ret_valid;
  rvfi_pkt_t   ret_pkt0;
  rvfi_pkt_t   ret_pkt1;
  logic        ret_ready;
  logic        mon_valid;
  logic [63:0] mon_order;
  rvfi_pkt_t   mon_pkt;
  logic        mon_error;
  logic        halted;

  rvfi_retire_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ret_valid (ret_valid),
    .ret_pkt0  (ret_pkt0),
    .ret_pkt1  (ret_pkt1),
    .ret_ready (ret_ready),
    .mon_valid (mon_valid),
    .mon_order (mon_order),
    .mon_pkt   (mon_pkt),
    .mon_error (mon_error),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: program-order queue plus the observable output registers.
  rvfi_entry_t mq[$];
  logic [63:0] m_order;
  bit          m_stop;
  bit          m_err;
  bit          m_halted;
  bit          m_have_last;
  logic [31:0] m_last_pc;
  bit          e_valid;
  logic [63:0] e_order;
  rvfi_pkt_t   e_pkt;
  bit          acc0;
  bit          acc1;

  int          n_emit;
  int          cyc_cnt;
  int          first_vld;
  logic [63:0] last_emit_order;
  rvfi_pkt_t   pz;

  task automatic model_reset();
    mq.delete();
    m_order = '0; m_stop = 0; m_err = 0; m_halted = 0;
    m_have_last = 0; m_last_pc = '0;
    e_valid = 0; e_order = '0; e_pkt = '0;
    acc0 = 0; acc1 = 0;
  endtask

  function automatic bit model_ready();
    return !m_stop && (mq.size() <= DEPTH - 2);
  endfunction

  task automatic model_step(input logic [1:0] v, input rvfi_pkt_t p0, input rvfi_pkt_t p1);
    bit rdy;
    rvfi_entry_t h;
    rdy  = model_ready();
    acc0 = 0;
    acc1 = 0;
    if (e_valid) begin
      if (m_have_last && e_pkt.pc_rdata != m_last_pc) m_err = 1;
      m_last_pc   = e_pkt.pc_wdata;
      m_have_last = 1;
      if (e_pkt.halt) m_halted = 1;
    end
    if (mq.size() > 0) begin
      h       = mq.pop_front();
      e_valid = 1;
      e_order = h.order;
      e_pkt   = h.pkt;
    end else begin
      e_valid = 0;
    end
    if (v == 2'b10) begin
      m_err = 1;
    end else if (v != 2'b00 && !rdy) begin
      m_err = 1;
    end else if (v[0]) begin
      mq.push_back('{order: m_order, pkt: p0});
      m_order = m_order + 1;
      acc0 = 1;
      if (p0.halt) begin
        m_stop = 1;
      end else if (v[1]) begin
        mq.push_back('{order: m_order, pkt: p1});
        m_order = m_order + 1;
        acc1 = 1;
        if (p1.halt) m_stop = 1;
      end
    end
  endtask

  function automatic rvfi_pkt_t mk_pkt(input logic [31:0] pc);
    rvfi_pkt_t p;
    p.insn      = $urandom;
    p.halt      = 1'b0;
    p.rs1_addr  = 5'($urandom);
    p.rs2_addr  = 5'($urandom);
    p.rs1_rdata = $urandom;
    p.rs2_rdata = $urandom;
    p.rd_addr   = 5'($urandom);
    p.rd_wdata  = $urandom;
    p.pc_rdata  = pc;
    p.pc_wdata  = pc + 32'd4;
    p.mem_addr  = $urandom;
    p.mem_rmask = 4'($urandom);
    p.mem_wmask = 4'($urandom);
    p.mem_rdata = $urandom;
    p.mem_wdata = $urandom;
    return p;
  endfunction

  task automatic cycle(input logic [1:0] v, input rvfi_pkt_t p0, input rvfi_pkt_t p1);
    ret_valid = v;
    ret_pkt0  = p0;
    ret_pkt1  = p1;
    check("ret_ready", 512'(ret_ready), 512'(model_ready()));
    model_step(v, p0, p1);
    @(posedge clk);
    #1;
    check("mon_valid", 512'(mon_valid), 512'(e_valid));
    check("mon_order", 512'(mon_order), 512'(e_order));
    check("mon_pkt",   512'(mon_pkt),   512'(e_pkt));
    check("mon_error", 512'(mon_error), 512'(m_err));
    check("halted",    512'(halted),    512'(m_halted));
    if (mon_valid) begin
      n_emit++;
      last_emit_order = mon_order;
      if (first_vld < 0) first_vld = cyc_cnt;
    end
    cyc_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, pz, pz);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    ret_valid = 2'b00;
    ret_pkt0  = pz;
    ret_pkt1  = pz;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    n_emit    = 0;
    cyc_cnt   = 0;
    first_vld = -1;
    check("rst_mon_valid", 512'(mon_valid), 512'(0));
    check("rst_mon_order", 512'(mon_order), 512'(0));
    check("rst_mon_pkt",   512'(mon_pkt),   512'(0));
    check("rst_mon_error", 512'(mon_error), 512'(0));
    check("rst_halted",    512'(halted),    512'(0));
    check("rst_ret_ready", 512'(ret_ready), 512'(1));
  endtask

  initial begin
    logic [31:0] pc;
    rvfi_pkt_t   p0;
    rvfi_pkt_t   p1;
    int          offered;
    int          guard;
    bit          saw_low;
    int          r;
    logic [1:0]  v;

    pz  = '0;
    rst = 1'b1;
    ret_valid = 2'b00;
    ret_pkt0 = pz;
    ret_pkt1 = pz;
    repeat (2) @(posedge clk);

    // Three dual pushes with a continuous PC chain.
    do_reset();
    pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      p0 = mk_pkt(pc);
      p1 = mk_pkt(pc + 32'd4);
      pc = pc + 32'd8;
      cycle(2'b11, p0, p1);
    end
    idle(10);
    check("burst_emit_count", 512'(n_emit), 512'(6));
    check("burst_first_valid", 512'(first_vld), 512'(1));
    check("burst_error", 512'(mon_error), 512'(0));

    // Saturate the FIFO, stalling while ret_ready is low.
    do_reset();
    pc = 32'h1000;
    offered = 0;
    guard = 0;
    saw_low = 0;
    while (offered < 10 && guard < 200) begin
      guard++;
      if (ret_ready) begin
        p0 = mk_pkt(pc);
        p1 = mk_pkt(pc + 32'd4);
        pc = pc + 32'd8;
        cycle(2'b11, p0, p1);
        offered++;
      end else begin
        saw_low = 1;
        cycle(2'b00, pz, pz);
      end
    end
    idle(24);
    check("full_offered", 512'(offered), 512'(10));
    check("full_saw_backpressure", 512'(saw_low), 512'(1));
    check("full_emit_count", 512'(n_emit), 512'(20));
    check("full_last_order", 512'(last_emit_order), 512'(19));
    check("full_ready_back", 512'(ret_ready), 512'(1));

    // Lane1-only valid is illegal and consumes no order.
    do_reset();
    cycle(2'b10, mk_pkt(32'h0), mk_pkt(32'h4));
    idle(3);
    check("illegal10_error", 512'(mon_error), 512'(1));
    check("illegal10_emit", 512'(n_emit), 512'(0));
    cycle(2'b01, mk_pkt(32'h0), pz);
    idle(3);
    check("illegal10_next_order", 512'(last_emit_order), 512'(0));

    // Valid while ret_ready is low is dropped and flagged.
    do_reset();
    pc = 32'h0;
    guard = 0;
    while (ret_ready && guard < 50) begin
      guard++;
      p0 = mk_pkt(pc);
      p1 = mk_pkt(pc + 32'd4);
      pc = pc + 32'd8;
      cycle(2'b11, p0, p1);
    end
    check("stall_reached", 512'(ret_ready), 512'(0));
    cycle(2'b01, mk_pkt(pc), pz);
    idle(20);
    check("stall_error", 512'(mon_error), 512'(1));
    check("stall_emit_all", 512'(n_emit), 512'(m_order));

    // Halt on lane0 with lane1 valid at order 4.
    do_reset();
    pc = 32'h200;
    for (int i = 0; i < 2; i++) begin
      p0 = mk_pkt(pc);
      p1 = mk_pkt(pc + 32'd4);
      pc = pc + 32'd8;
      cycle(2'b11, p0, p1);
    end
    p0 = mk_pkt(pc);
    p0.halt = 1'b1;
    p1 = mk_pkt(pc + 32'd4);
    cycle(2'b11, p0, p1);
    check("halt_ready_low", 512'(ret_ready), 512'(0));
    idle(12);
    check("halt_emit_count", 512'(n_emit), 512'(5));
    check("halt_last_order", 512'(last_emit_order), 512'(4));
    check("halt_halted", 512'(halted), 512'(1));
    check("halt_error", 512'(mon_error), 512'(0));

    // PC discontinuity between consecutive emitted packets.
    do_reset();
    p0 = mk_pkt(32'hFC);
    cycle(2'b01, p0, pz);
    p0 = mk_pkt(32'h104);
    cycle(2'b01, p0, pz);
    idle(5);
    check("pc_break_error", 512'(mon_error), 512'(1));

    // Reset with entries buffered discards them.
    do_reset();
    pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      p0 = mk_pkt(pc);
      p1 = mk_pkt(pc + 32'd4);
      pc = pc + 32'd8;
      cycle(2'b11, p0, p1);
    end
    do_reset();
    idle(2);
    check("midrst_no_output", 512'(n_emit), 512'(0));
    cycle(2'b01, mk_pkt(32'h40), pz);
    idle(3);
    check("midrst_emit", 512'(n_emit), 512'(1));
    check("midrst_order0", 512'(last_emit_order), 512'(0));

    // Random segments.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      pc = {$urandom_range(0, 32'hFFFF), 2'b00};
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 99);
        if (r < 40)      v = 2'b11;
        else if (r < 75) v = 2'b01;
        else if (r < 97) v = 2'b00;
        else             v = 2'b10;
        if (!model_ready() && ($urandom_range(0, 9) != 0)) v = 2'b00;
        p0 = mk_pkt(pc);
        if ($urandom_range(0, 99) < 3) p0.pc_rdata = pc + 32'd8;
        p0.halt = ($urandom_range(0, 99) < 2);
        p1 = mk_pkt(p0.pc_wdata);
        p1.halt = ($urandom_range(0, 99) < 2);
        cycle(v, p0, p1);
        if (acc1)      pc = p1.pc_wdata;
        else if (acc0) pc = p0.pc_wdata;
      end
      idle(12);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
